// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch stage
package ifu_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam int          PC_STEP   = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HALT
    } fetch_state_t;

    // Slot storage is 32 bits wide; narrower fetch widths are zero-extended into it.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fill;
    } slot_t;

endpackage

// File: rtl/ifu_if.sv
// rtl/ifu_if.sv - fetch-stage bus: imem request/response, EX redirect, IF/ID handoff; id_misalign under IFU_MISALIGN_CHK_EN
interface ifu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rsp_data;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  id_valid;
    logic                  id_ready;
    logic [DATA_WIDTH-1:0] id_instr;
    logic [ADDR_WIDTH-1:0] id_pc;

`ifdef IFU_MISALIGN_CHK_EN
    logic                  id_misalign;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_misalign,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_misalign,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
    );
`else
    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
    );
`endif

endinterface

// File: rtl/ifu_slot_buf.sv
// rtl/ifu_slot_buf.sv - circular fetch buffer: slots reserved at issue, filled in order by responses, popped at the head
module ifu_slot_buf
    import ifu_pkg::*;
#(
    parameter  int DEPTH      = 2,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    localparam int PW         = $clog2(DEPTH),
    localparam int CW         = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  reserve,
    input  logic [ADDR_WIDTH-1:0] reserve_pc,
    input  logic                  reserve_filled,
    input  logic [DATA_WIDTH-1:0] reserve_instr,
    input  logic                  fill,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  pop,
    output slot_t                 head,
    output logic [CW-1:0]         occupancy,
    output logic [CW-1:0]         unfilled
);
    slot_t         mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic [PW-1:0] fill_ptr;

    assign head = mem[head_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            head_ptr  <= '0;
            tail_ptr  <= '0;
            fill_ptr  <= '0;
            occupancy <= '0;
            unfilled  <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) mem[i].fill <= 1'b0;
            head_ptr <= '0;
            // A flush may load one entry in the same cycle (the misaligned-redirect NOP).
            if (reserve) begin
                mem[0]    <= '{pc: 32'(reserve_pc), instr: 32'(reserve_instr), fill: reserve_filled};
                tail_ptr  <= PW'(1);
                fill_ptr  <= reserve_filled ? PW'(1) : '0;
                occupancy <= CW'(1);
                unfilled  <= reserve_filled ? '0 : CW'(1);
            end else begin
                tail_ptr  <= '0;
                fill_ptr  <= '0;
                occupancy <= '0;
                unfilled  <= '0;
            end
        end else begin
            if (reserve) begin
                mem[tail_ptr].pc   <= 32'(reserve_pc);
                mem[tail_ptr].fill <= 1'b0;
                tail_ptr           <= tail_ptr + PW'(1);
            end
            if (fill) begin
                mem[fill_ptr].instr <= 32'(fill_data);
                mem[fill_ptr].fill  <= 1'b1;
                fill_ptr            <= fill_ptr + PW'(1);
            end
            if (pop) begin
                mem[head_ptr].fill <= 1'b0;
                head_ptr           <= head_ptr + PW'(1);
            end
            occupancy <= occupancy + CW'(reserve) - CW'(pop);
            unfilled  <= unfilled + CW'(reserve) - CW'(fill);
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - RV32 fetch stage: PC, fetch FSM, credit and stale-response dropping
// IFU_MISALIGN_CHK_EN: misaligned redirects enqueue a flagged NOP and halt fetch
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    ifu_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] redir_pc;
    logic [CW-1:0]         drop_cnt;
    logic [CW-1:0]         drop_nxt;
    logic [CW-1:0]         occupancy;
    logic [CW-1:0]         unfilled;
    slot_t                 head;
    logic                  misalign;
    logic                  req_fire;
    logic                  rsp_fill;
    logic                  pop;
    logic                  reserve;

`ifdef IFU_MISALIGN_CHK_EN
    assign redir_pc        = bus.redirect_pc;
    assign misalign        = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    // While halted the only live entry is the trap NOP.
    assign bus.id_misalign = bus.id_valid && (state == HALT);
`else
    assign redir_pc = bus.redirect_pc & ~ADDR_WIDTH'(3);
    assign misalign = 1'b0;
`endif

    always_comb begin
        bus.imem_req_valid = ((state == RUN) || (state == DRAIN)) &&
                             (occupancy < CW'(DEPTH)) && !bus.redirect_valid;
        bus.imem_req_addr  = pc;
        req_fire           = bus.imem_req_valid && bus.imem_req_ready;
        bus.id_valid       = (occupancy != '0) && head.fill && !bus.redirect_valid;
        bus.id_pc          = (occupancy != '0) ? ADDR_WIDTH'(head.pc)    : '0;
        bus.id_instr       = (occupancy != '0) ? DATA_WIDTH'(head.instr) : '0;
        pop                = bus.id_valid && bus.id_ready;
        reserve            = req_fire || misalign;
        rsp_fill           = bus.imem_rsp_valid && (drop_cnt == '0) && !bus.redirect_valid;
        // Responses still owed to flushed slots must be swallowed before new ones land.
        drop_nxt = drop_cnt;
        if (bus.redirect_valid)
            drop_nxt = drop_cnt + unfilled - CW'(bus.imem_rsp_valid);
        else if (bus.imem_rsp_valid && (drop_cnt != '0))
            drop_nxt = drop_cnt - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_nxt;
            if (bus.redirect_valid)
                pc <= redir_pc;
            else if (req_fire)
                pc <= pc + ADDR_WIDTH'(PC_STEP);
            if (bus.redirect_valid)
                state <= misalign ? HALT : ((drop_nxt != '0) ? DRAIN : RUN);
            else if (state == IDLE)
                state <= RUN;
            else if (state != HALT)
                state <= (drop_nxt != '0) ? DRAIN : RUN;
        end
    end

    ifu_slot_buf #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot_buf (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (bus.redirect_valid),
        .reserve        (reserve),
        .reserve_pc     (misalign ? redir_pc : pc),
        .reserve_filled (misalign),
        .reserve_instr  (DATA_WIDTH'(INSTR_NOP)),
        .fill           (rsp_fill),
        .fill_data      (bus.imem_rsp_data),
        .pop            (pop),
        .head           (head),
        .occupancy      (occupancy),
        .unfilled       (unfilled)
    );

    a_rsp_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        bus.imem_rsp_valid |-> ((unfilled != '0) || (drop_cnt != '0)));

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed bench for ifu_fetch with an in-order fixed-latency memory model
module tb_ifu_fetch;
    import ifu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ifu_if bus ();
    ifu_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int lat          = 1;
    int first_valid_cyc;
    int redir_cyc;

    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [31:0] acc_addr[$];
    int          acc_cyc[$];
    logic [31:0] del_pc[$];
    logic [31:0] del_ins[$];
    logic        del_mis[$];

    logic        ready_drv;
    logic        idr_drv;
    logic        redir_drv;
    logic [31:0] redir_pc_drv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_seq(input string tag, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] exp_pc;
            exp_pc = base + 32'(4 * i);
            check({tag, " pc"},    (i < del_pc.size())  ? del_pc[i]  : 32'hDEAD_DEAD, exp_pc);
            check({tag, " instr"}, (i < del_ins.size()) ? del_ins[i] : 32'hDEAD_DEAD, exp_pc ^ 32'hA5A5_0000);
        end
    endtask

    task automatic clear_logs();
        acc_addr.delete(); acc_cyc.delete();
        del_pc.delete(); del_ins.delete(); del_mis.delete();
        first_valid_cyc = -1;
    endtask

    // One clock: drive memory response and stimulus at the falling edge, then observe.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (q_due.size() != 0 && q_due[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = q_addr[0] ^ 32'hA5A5_0000;
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
        bus.imem_req_ready = ready_drv;
        bus.id_ready       = idr_drv;
        bus.redirect_valid = redir_drv;
        bus.redirect_pc    = redir_pc_drv;
        #1;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            q_addr.push_back(bus.imem_req_addr);
            q_due.push_back(cyc + lat);
            acc_addr.push_back(bus.imem_req_addr);
            acc_cyc.push_back(cyc);
        end
        if (bus.id_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.id_valid && bus.id_ready) begin
            del_pc.push_back(bus.id_pc);
            del_ins.push_back(bus.id_instr);
`ifdef IFU_MISALIGN_CHK_EN
            del_mis.push_back(bus.id_misalign);
`else
            del_mis.push_back(1'b0);
`endif
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redir_drv    = 1'b1;
        redir_pc_drv = target;
        tick();
        redir_cyc    = cyc;
        redir_drv    = 1'b0;
    endtask

    task automatic do_reset(input int latency);
        @(negedge clk);
        rst_n              = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b0;
        redir_drv          = 1'b0;
        redir_pc_drv       = '0;
        q_addr.delete(); q_due.delete();
        clear_logs();
        lat = latency;
        #1;
        check("rst req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst id_valid",  32'(bus.id_valid), 32'd0);
        check("rst id_pc",     bus.id_pc, 32'd0);
        check("rst id_instr",  bus.id_instr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle req_valid", 32'(bus.imem_req_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time %0t, limit 1000000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        ready_drv    = 1'b0;
        idr_drv      = 1'b0;
        redir_drv    = 1'b0;
        redir_pc_drv = '0;

        // Zero-wait streaming
        do_reset(1);
        ready_drv = 1'b1;
        idr_drv   = 1'b1;
        ticks(14);
        check("t1 first accept addr", (acc_addr.size() > 0) ? acc_addr[0] : 32'hDEAD_DEAD, 32'h0);
        check("t1 issue-to-valid", 32'(first_valid_cyc - ((acc_cyc.size() > 0) ? acc_cyc[0] : 0)), 32'd2);
        check_seq("t1", 32'h0, 4);

        // Decode stall: credit limits fetch to DEPTH
        do_reset(1);
        ready_drv = 1'b1;
        idr_drv   = 1'b0;
        ticks(10);
        check("t2 accepts while stalled", 32'(acc_addr.size()), 32'd2);
        check("t2 req_valid full", 32'(bus.imem_req_valid), 32'd0);
        check("t2 id_valid full", 32'(bus.id_valid), 32'd1);
        idr_drv = 1'b1;
        ticks(12);
        check_seq("t2", 32'h0, 5);

        // Redirect with two requests in flight
        do_reset(3);
        ready_drv = 1'b1;
        idr_drv   = 1'b1;
        for (int i = 0; i < 20 && acc_addr.size() < 2; i++) tick();
        check("t3 two in flight", 32'(acc_addr.size()), 32'd2);
        redirect_to(32'h100);
        check("t3 redirect req_valid", 32'(bus.imem_req_valid), 32'd0);
        tick();
        check("t3 drop_cnt", 32'(dut.drop_cnt), 32'd2);
        check("t3 state", 32'(dut.state), 32'(DRAIN));
        check("t3 first req after redirect", (acc_addr.size() > 2) ? acc_addr[2] : 32'hDEAD_DEAD, 32'h100);
        check("t3 req next cycle", 32'((acc_cyc.size() > 2) ? acc_cyc[2] : 0), 32'(redir_cyc + 1));
        ticks(14);
        check_seq("t3", 32'h100, 2);

        // Redirect colliding with a response and a would-be handshake
        do_reset(1);
        ready_drv = 1'b1;
        idr_drv   = 1'b1;
        ticks(2);
        redirect_to(32'h300);
        check("t4 id_valid on redirect", 32'(bus.id_valid), 32'd0);
        check("t4 no handshake", 32'(del_pc.size()), 32'd0);
        tick();
        check("t4 drop_cnt", 32'(dut.drop_cnt), 32'd0);
        check("t4 state", 32'(dut.state), 32'(RUN));
        ticks(10);
        check_seq("t4", 32'h300, 2);

        // Request backpressure with 3-cycle memory latency
        do_reset(3);
        idr_drv   = 1'b1;
        ready_drv = 1'b1;
        tick();
        ready_drv = 1'b0;
        tick();
        check("t5 stall valid", 32'(bus.imem_req_valid), 32'd1);
        check("t5 stall addr a", bus.imem_req_addr, 32'h4);
        tick();
        check("t5 stall addr b", bus.imem_req_addr, 32'h4);
        ready_drv = 1'b1;
        tick();
        check("t5 accepted after stall", (acc_addr.size() > 1) ? acc_addr[1] : 32'hDEAD_DEAD, 32'h4);
        ticks(24);
        check_seq("t5", 32'h0, 4);

`ifdef IFU_MISALIGN_CHK_EN
        // Misaligned redirect traps and halts fetch
        do_reset(1);
        ready_drv = 1'b1;
        idr_drv   = 1'b1;
        ticks(4);
        clear_logs();
        redirect_to(32'h102);
        ticks(10);
        check("t6 no fetch while halted", 32'(acc_addr.size()), 32'd0);
        check("t6 one entry", 32'(del_pc.size()), 32'd1);
        check("t6 nop pc", (del_pc.size() > 0) ? del_pc[0] : 32'hDEAD_DEAD, 32'h102);
        check("t6 nop instr", (del_ins.size() > 0) ? del_ins[0] : 32'hDEAD_DEAD, 32'h0000_0013);
        check("t6 misalign flag", 32'((del_mis.size() > 0) ? del_mis[0] : 1'b0), 32'd1);
        redirect_to(32'h200);
        ticks(10);
        check("t6 resume addr", (acc_addr.size() > 0) ? acc_addr[0] : 32'hDEAD_DEAD, 32'h200);
        check("t6 resume pc", (del_pc.size() > 1) ? del_pc[1] : 32'hDEAD_DEAD, 32'h200);
        check("t6 resume flag", 32'((del_mis.size() > 1) ? del_mis[1] : 1'b1), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
